wb_target_regbank: RTL and testbench
====================================

// Module: wb_target_regbank
// PURPOSE
//  Wishbone B4 slave register bank: the responder for the fuzzer's wbm_* master port.
//  Gives the central fuzzer a deterministic target during bring-up and regression,
//  with programmable ack latency, incrementing/wrapping bursts, error responses for
//  bad addresses, and transaction/error counters the bench reads back.
// PARAMETERS
//  ADDR_WIDTH  32            Wishbone address width
//  DATA_WIDTH  32            data width; byte lanes = DATA_WIDTH/8
//  DEPTH       16            number of DATA_WIDTH words; power of 2, >=16
//  BASE_ADDR   32'h3000_0000 byte address of word 0
//  ACK_DELAY   1             wait cycles before the first ack of a cycle; 0..7
// PORTS
//  clk             in   1            clock
//  rst             in   1            async active-high reset
//  wbs_cyc_i       in   1            bus cycle valid
//  wbs_stb_i       in   1            strobe
//  wbs_we_i        in   1            1 = write
//  wbs_adr_i       in   ADDR_WIDTH   byte address
//  wbs_dat_i       in   DATA_WIDTH   write data
//  wbs_sel_i       in   DATA_WIDTH/8 byte enables
//  wbs_cti_i       in   3            000 classic, 010 incr burst, 111 end of burst
//  wbs_bte_i       in   2            00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wbs_dat_o       out  DATA_WIDTH   read data; valid only while ack is high, else 0
//  wbs_ack_o       out  1            normal termination
//  wbs_err_o       out  1            error termination
//  txn_count_o     out  16           acked beats, saturating
//  err_count_o     out  16           err beats, saturating
// BEHAVIOUR
//  Reset (async): all outputs 0; memory cleared to 0; FSM in IDLE; counters 0.
//  Decode: hit = adr>=BASE_ADDR and adr[1:0]==0 and (adr-BASE_ADDR)>>2 < DEPTH.
//    A miss terminates with wbs_err_o instead of wbs_ack_o. Memory is untouched.
//  FSM states: IDLE, WAIT, RESP, BURST.
//  IDLE: cyc&stb seen -> latch adr/we/cti/bte, wait_cnt=ACK_DELAY.
//    Go to WAIT, or to RESP when ACK_DELAY=0.
//  WAIT: decrement wait_cnt; at 0 -> RESP.
//  RESP: ack or err high for exactly 1 cycle. First beat latency = ACK_DELAY+1 cycles
//    after the stb sample.
//    Write takes effect on this cycle, per sel byte lane. Read data is driven here.
//    Next state: classic (cti!=010), an err beat, or an 111 beat -> IDLE, which forces
//    >=1 idle cycle before the next classic ack. cti==010 -> BURST.
//  BURST: one beat per cycle with zero wait while cyc&stb.
//    Internal word pointer advances each beat and wbs_adr_i is ignored.
//    bte 00 increments linearly; 01/10/11 wrap inside an aligned 4/8/16-word block.
//    A linear burst crossing DEPTH gives err on that beat and ends the burst.
//    stb low with cyc high: no ack, hold state and pointer.
//    Beat with cti==111 acked -> IDLE.
//  ack and err are never high together and never high while cyc is low.
//  cyc drop in any state -> IDLE next cycle. ack/err low in that cycle.
//    A pending write that was never acked is discarded.
//  Simultaneous ack and cyc drop in the same cycle: the beat counts and the write lands.
//  Counters: txn +1 per ack, err +1 per err, both hold at 16'hFFFF.
//  Reset mid-transaction: immediate IDLE, outputs 0, memory cleared.
// TESTING
//  1 Classic write 0xDEADBEEF to 0x3000_0004, sel=1111, ACK_DELAY=1
//    -> ack in cycle 2 after stb; read back 0xDEADBEEF; txn_count=2.
//  2 Write 0xAABBCCDD to word 0 with sel=0101 over memory holding 0x11223344
//    -> read returns 0x11BB33DD.
//  3 Read 0x2FFF_FFFC, read 0x3000_0040, write 0x3000_0002
//    -> err each; no ack; err_count=3; memory unchanged.
//  4 Incr burst, bte=01, start word 2, 4 beats, last beat cti=111
//    -> words 2,3,0,1 accessed; ack on 4 consecutive cycles; then IDLE.
//  5 cyc dropped during WAIT with ACK_DELAY=5 on a write
//    -> no ack; memory unchanged; next transaction completes normally.
//  6 Assert rst during BURST beat 2 -> all outputs 0 same cycle; memory reads 0 after reset.

Source files
------------

// File: rtl/wb_target_regbank.sv
// Wishbone B4 slave register bank used as a deterministic target for the fuzzer's
// master port. It provides programmable first-beat latency, incrementing and wrapping
// bursts, error termination for bad addresses, and saturating ack/err beat counters.
module wb_target_regbank #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h3000_0000,
    parameter int                    ACK_DELAY  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
    input  logic [2:0]              wbs_cti_i,
    input  logic [1:0]              wbs_bte_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_ack_o,
    output logic                    wbs_err_o,
    output logic [15:0]             txn_count_o,
    output logic [15:0]             err_count_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [1:0] BTE_LIN  = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_BURST
    } state_t;

    state_t                  state, state_d;
    logic [2:0]              wait_cnt;
    logic                    we_q;
    logic [2:0]              cti_q;
    logic [1:0]              bte_q;
    logic                    miss_q;
    logic                    ovf_q;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        ptr_inc;
    logic [IDX_W-1:0]        wrap_mask;
    logic [IDX_W-1:0]        next_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [15:0]             txn_cnt;
    logic [15:0]             err_cnt;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   off_words;
    logic                    adr_hit;
    logic                    start;
    logic                    beat;
    logic                    beat_err;

    // Address decode of the live bus address; only consulted when a cycle starts.
    assign offset    = wbs_adr_i - BASE_ADDR;
    assign off_words = offset >> 2;
    assign adr_hit   = (wbs_adr_i >= BASE_ADDR) && (wbs_adr_i[1:0] == 2'b00)
                       && (off_words < ADDR_WIDTH'(DEPTH));

    assign start = (state == S_IDLE) && wbs_cyc_i && wbs_stb_i;

    // A beat completes whenever the master strobes while we are presenting a response.
    // Gating with cyc keeps ack/err low in the cycle the master abandons the bus.
    assign beat     = wbs_cyc_i && wbs_stb_i && ((state == S_RESP) || (state == S_BURST));
    assign beat_err = (state == S_RESP) ? miss_q : ovf_q;

    assign wbs_ack_o   = beat && !beat_err;
    assign wbs_err_o   = beat && beat_err;
    assign wbs_dat_o   = wbs_ack_o ? mem[ptr] : '0;
    assign txn_count_o = txn_cnt;
    assign err_count_o = err_cnt;

    // Burst pointer advance: linear increment, or increment confined to an aligned block.
    always_comb begin
        // NOTE: always_comb uses blocking '=' and assigns every output a default first,
        // so no path leaves a variable unassigned and no latch is inferred.
        ptr_inc   = ptr + 1'b1;
        wrap_mask = '0;
        unique case (bte_q)
            2'b01:   wrap_mask = IDX_W'(3);
            2'b10:   wrap_mask = IDX_W'(7);
            2'b11:   wrap_mask = IDX_W'(15);
            default: wrap_mask = '0;
        endcase
        if (bte_q == BTE_LIN) next_ptr = ptr_inc;
        else                  next_ptr = (ptr & ~wrap_mask) | (ptr_inc & wrap_mask);
    end

    // Next-state logic; losing cyc returns to IDLE from any state.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (wbs_cyc_i && wbs_stb_i)
                         state_d = (ACK_DELAY == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (wait_cnt == 3'd1) state_d = S_RESP;
            S_RESP:  if (beat)
                         state_d = (miss_q || (cti_q != CTI_INCR)) ? S_IDLE : S_BURST;
            S_BURST: if (beat && (ovf_q || (wbs_cti_i != CTI_INCR))) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!wbs_cyc_i) state_d = S_IDLE;
    end

    // State register plus the request context captured at the start of a cycle.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            cti_q    <= '0;
            bte_q    <= '0;
            miss_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ptr      <= '0;
        end else begin
            state <= state_d;
            if (start) begin
                we_q     <= wbs_we_i;
                cti_q    <= wbs_cti_i;
                bte_q    <= wbs_bte_i;
                miss_q   <= !adr_hit;
                ovf_q    <= 1'b0;
                ptr      <= off_words[IDX_W-1:0];
                wait_cnt <= 3'(ACK_DELAY);
            end
            if (state == S_WAIT) wait_cnt <= wait_cnt - 1'b1;
            if (beat) begin
                ptr   <= next_ptr;
                // Stepping past the last word in a linear burst makes the next beat err.
                ovf_q <= (bte_q == BTE_LIN) && (ptr == IDX_W'(DEPTH - 1));
            end
        end
    end

    // Register storage: byte-lane writes land only on an acked write beat.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is built from flops and must read as zero after reset, so it
        // is cleared in the reset branch rather than left to power-up contents.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wbs_ack_o && we_q) begin
            for (int b = 0; b < NB; b++) begin
                if (wbs_sel_i[b]) mem[ptr][b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
            end
        end
    end

    // Saturating beat counters for ack and err terminations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (wbs_ack_o && (txn_cnt != 16'hFFFF)) txn_cnt <= txn_cnt + 16'd1;
            if (wbs_err_o && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_target_regbank.sv
// Self-checking bench for wb_target_regbank: a table of classic transfers plus
// hand-written burst, abort and mid-burst reset sequences.
module tb_wb_target_regbank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance, ACK_DELAY = 1
    logic        cyc = 0, stb = 0, we = 0;
    logic [31:0] adr = 0, dat_w = 0;
    logic [3:0]  sel = 0;
    logic [2:0]  cti = 0;
    logic [1:0]  bte = 0;
    logic [31:0] dat_r;
    logic        ack, err;
    logic [15:0] txn, errc;

    // Second instance, ACK_DELAY = 5
    logic        c5 = 0, s5 = 0, w5 = 0;
    logic [31:0] a5 = 0, dw5 = 0;
    logic [3:0]  sel5 = 4'hF;
    logic [2:0]  cti5 = 0;
    logic [1:0]  bte5 = 0;
    logic [31:0] dr5;
    logic        ack5, err5;
    logic [15:0] txn5, errc5;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_target_regbank #(.ACK_DELAY(1)) u_dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
        .wbs_dat_i(dat_w), .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte),
        .wbs_dat_o(dat_r), .wbs_ack_o(ack), .wbs_err_o(err),
        .txn_count_o(txn), .err_count_o(errc)
    );

    wb_target_regbank #(.ACK_DELAY(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(c5), .wbs_stb_i(s5), .wbs_we_i(w5), .wbs_adr_i(a5),
        .wbs_dat_i(dw5), .wbs_sel_i(sel5), .wbs_cti_i(cti5), .wbs_bte_i(bte5),
        .wbs_dat_o(dr5), .wbs_ack_o(ack5), .wbs_err_o(err5),
        .txn_count_o(txn5), .err_count_o(errc5)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Classic single transfer on the main instance; lat = clock edges from the
    // strobe-sampling edge up to and including the edge that starts the ack cycle.
    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic got_ack, output logic got_err, output int lat);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat_w = d; sel = s; cti = 3'b000; bte = 2'b00;
        lat = 0; got_ack = 0; got_err = 0; rd = '0;
        while (!(got_ack || got_err) && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (ack || err) begin
                got_ack = ack; got_err = err; rd = dat_r;
            end
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic classic5(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic got_ack, output int lat);
        @(posedge clk); #1;
        c5 = 1; s5 = 1; w5 = w; a5 = a; dw5 = d;
        lat = 0; got_ack = 0; rd = '0;
        while (!got_ack && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (ack5 || err5) begin
                got_ack = ack5; rd = dr5;
            end
        end
        @(posedge clk); #1;
        c5 = 0; s5 = 0; w5 = 0;
    endtask

    // Burst of n (<=4) beats, last beat cti=111; adr is scrambled after the first
    // beat since the target must ignore it. Optionally stalls stb for one cycle.
    task automatic burst(input logic w, input logic [31:0] a, input logic [1:0] b,
                         input int n, input int stall_at, input logic [31:0] d [4],
                         output logic [31:0] rd [4], output logic [3:0] acks,
                         output logic [3:0] errs, output int idle_cycles);
        int beat;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; bte = b; sel = 4'hF; dat_w = d[0];
        cti = (n == 1) ? 3'b111 : 3'b010;
        beat = 0; idle_cycles = 0; acks = '0; errs = '0;
        for (int i = 0; i < 4; i++) rd[i] = '0;
        while (beat < n && idle_cycles < 20) begin
            @(negedge clk);
            if (ack || err) begin
                acks[beat] = ack; errs[beat] = err; rd[beat] = dat_r;
                beat++;
                @(posedge clk); #1;
                if (beat < n) begin
                    dat_w = d[beat];
                    adr   = 32'hFFFF_FFF0;
                    cti   = (beat == n - 1) ? 3'b111 : 3'b010;
                end
                if (beat == stall_at && beat < n) begin
                    stb = 0;
                    @(negedge clk);
                    check("burst stall no resp", {ack, err}, 2'b00);
                    @(posedge clk); #1;
                    stb = 1;
                end
            end else begin
                idle_cycles++;
                @(posedge clk); #1;
            end
        end
        // A new classic request right after the final beat: back in IDLE it cannot be
        // answered in this cycle.
        we = 0; cti = 3'b000; adr = 32'h3000_0000;
        @(negedge clk);
        check("burst end idle", {ack, err}, 2'b00);
        @(posedge clk); #1;
        cyc = 0; stb = 0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        logic        ga, ge;
        int          lat, idle;
        logic [31:0] bd [4];
        logic [31:0] brd [4];
        logic [3:0]  backs, berrs;
        logic        seen;

        vecs[0]  = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h3000_0000, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h3000_0000, 32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'h11BB_33DD};
        vecs[5]  = '{1'b0, 32'h2FFF_FFFC, 32'h0,         4'hF, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h3000_0040, 32'h0,         4'hF, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 32'h3000_0002, 32'h5555_5555, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'h11BB_33DD};
        vecs[9]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 32'h3000_003C, 32'h0F0F_0F0F, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h3000_003C, 32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'h0F0F_0F0F};

        // Reset state
        #2;
        check("reset ack/err", {ack, err}, 2'b00);
        check("reset dat_o", dat_r, 32'h0);
        check("reset counters", {txn, errc}, 32'h0);
        @(posedge clk); #1;
        rst = 0;

        // Classic transfers, byte lanes and decode errors
        for (int i = 0; i < 12; i++) begin
            classic(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, ga, ge, lat);
            check($sformatf("v%0d ack", i), ga, vecs[i].exp_ack);
            check($sformatf("v%0d err", i), ge, vecs[i].exp_err);
            check($sformatf("v%0d latency", i), lat, 2);
            if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
            if (i == 1) check("txn after readback", txn, 16'd2);
            if (i == 7) check("err count after misses", errc, 16'd3);
        end
        check("txn after table", txn, 16'd9);

        // Wrap4 burst write from word 2: words 2,3,0,1
        bd[0] = 32'hA000_0000; bd[1] = 32'hA111_1111; bd[2] = 32'hA222_2222; bd[3] = 32'hA333_3333;
        burst(1'b1, 32'h3000_0008, 2'b01, 4, -1, bd, brd, backs, berrs, idle);
        check("wrap4 wr acks", backs, 4'b1111);
        check("wrap4 wr errs", berrs, 4'b0000);
        check("wrap4 wr first-beat wait", idle, 2);
        classic(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, ga, ge, lat);
        check("wrap4 word0", rd, 32'hA222_2222);
        classic(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd, ga, ge, lat);
        check("wrap4 word1", rd, 32'hA333_3333);
        classic(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, ga, ge, lat);
        check("wrap4 word2", rd, 32'hA000_0000);
        classic(1'b0, 32'h3000_000C, 32'h0, 4'hF, rd, ga, ge, lat);
        check("wrap4 word3", rd, 32'hA111_1111);

        // Wrap4 burst read with a one-cycle strobe stall before beat 2
        burst(1'b0, 32'h3000_0008, 2'b01, 4, 2, bd, brd, backs, berrs, idle);
        check("wrap4 rd acks", backs, 4'b1111);
        check("wrap4 rd wait", idle, 2);
        check("wrap4 rd data", {brd[0], brd[1]}, {32'hA000_0000, 32'hA111_1111});
        check("wrap4 rd data hi", {brd[2], brd[3]}, {32'hA222_2222, 32'hA333_3333});

        // Wrap8 burst read from word 6: words 6,7,0,1
        burst(1'b0, 32'h3000_0018, 2'b10, 4, -1, bd, brd, backs, berrs, idle);
        check("wrap8 rd acks", backs, 4'b1111);
        check("wrap8 rd data", {brd[0], brd[1]}, {32'h0, 32'h0});
        check("wrap8 rd data hi", {brd[2], brd[3]}, {32'hA222_2222, 32'hA333_3333});

        // Linear burst running off the end: words 14,15 ack, then err
        burst(1'b0, 32'h3000_0038, 2'b00, 3, -1, bd, brd, backs, berrs, idle);
        check("linear ovf acks", backs, 4'b0011);
        check("linear ovf errs", berrs, 4'b0100);
        check("linear ovf word15", brd[1], 32'h0F0F_0F0F);
        check("linear ovf err data", brd[2], 32'h0);
        check("txn after bursts", txn, 16'd27);
        check("err after bursts", errc, 16'd4);

        // Write abandoned during WAIT on the ACK_DELAY=5 instance
        @(posedge clk); #1;
        c5 = 1; s5 = 1; w5 = 1; a5 = 32'h3000_0008; dw5 = 32'h1234_5678;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= ack5 | err5;
        end
        c5 = 0; s5 = 0; w5 = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= ack5 | err5;
        end
        check("abort no resp", seen, 1'b0);
        classic5(1'b0, 32'h3000_0008, 32'h0, rd, ga, lat);
        check("abort mem unchanged", rd, 32'h0);
        check("delay5 latency", lat, 6);
        classic5(1'b1, 32'h3000_0008, 32'h1234_5678, rd, ga, lat);
        check("delay5 write ack", ga, 1'b1);
        classic5(1'b0, 32'h3000_0008, 32'h0, rd, ga, lat);
        check("delay5 readback", rd, 32'h1234_5678);
        check("delay5 txn", txn5, 16'd3);

        // Reset asserted during beat 2 of a linear burst write
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h3000_0010; bte = 2'b00; cti = 3'b010;
        sel = 4'hF; dat_w = 32'hCAFE_0001;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!ack && lat < 20);
        check("rst-burst beat1 ack", ack, 1'b1);
        @(posedge clk); #1;
        dat_w = 32'hCAFE_0002;
        @(negedge clk);
        check("rst-burst beat2 ack", ack, 1'b1);
        rst = 1;
        #1;
        check("rst-burst outputs", {ack, err, dat_r}, 34'h0);
        check("rst-burst counters", {txn, errc}, 32'h0);
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; cti = 3'b000;
        @(posedge clk); #1;
        rst = 0;
        classic(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd, ga, ge, lat);
        check("post-rst word0", {ga, rd}, {1'b1, 32'h0});
        classic(1'b0, 32'h3000_0010, 32'h0, 4'hF, rd, ga, ge, lat);
        check("post-rst word4", {ga, rd}, {1'b1, 32'h0});
        check("post-rst txn", txn, 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
